// File: rtl/async_fifo_pkg.sv
// Shared types and helpers for the async FIFO write-side arbiter and its round-robin picker.
// Pure declarations; no logic or timing of its own.
package async_fifo_pkg;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} arb_state_e;

  localparam int MAX_NREQ = 16;

  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/async_fifo_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after rr_ptr, with wrap.
// Zero latency; no backpressure of its own, the caller decides whether to honour the grant.
module async_fifo_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_vld
);

  localparam logic [IW:0] N_W = (IW+1)'(NREQ);

  logic [IW:0] pos;

  // Walk NREQ slots starting at rr_ptr; pos stays below 2*NREQ so one subtract wraps it.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, rr_ptr} + (IW+1)'(k);
      if (pos >= N_W) pos = pos - N_W;
      if (!gnt_vld && req[pos[IW-1:0]]) begin
        gnt_vld              = 1'b1;
        gnt_idx              = pos[IW-1:0];
        gnt[pos[IW-1:0]]     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/async_fifo_wr_arb.sv
// Packet-locked round-robin arbiter sharing one FIFO write port; accepted beat reaches push/wdata in the same cycle.
// full stalls everything: no ready, no push, no state change.
module async_fifo_wr_arb
  import async_fifo_pkg::*;
#(
  parameter int DWIDTH    = 8,
  parameter int NREQ      = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                      wclk,
  input  logic                      reset_L,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*DWIDTH-1:0]    req_data,
  input  logic [NREQ-1:0]           req_last,
  output logic [NREQ-1:0]           req_ready,
  output logic                      push,
  output logic [DWIDTH-1:0]         wdata,
  input  logic                      full,
  output logic                      busy,
  output logic [$clog2(NREQ)-1:0]   lock_id,
  output logic [NREQ*CNT_WIDTH-1:0] pkt_cnt
);

  localparam int IW = $clog2(NREQ);

  arb_state_e           state_q, state_d;
  logic [IW-1:0]        rr_ptr_q, owner_q;
  logic [CNT_WIDTH-1:0] cnt_q [NREQ];

  logic [NREQ-1:0]      pick_gnt, grant_mask;
  logic [IW-1:0]        pick_idx, sel;
  logic                 pick_vld, accept, sel_last;
  logic [DWIDTH-1:0]    data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_a[i]                          = req_data[i*DWIDTH +: DWIDTH];
    assign pkt_cnt[i*CNT_WIDTH +: CNT_WIDTH]  = cnt_q[i];
  end

  async_fifo_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .gnt_vld (pick_vld)
  );

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !sel_last) state_d = LOCKED;
      LOCKED:  if (accept &&  sel_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // While locked the owner keeps ready even when it has no beat, so nobody else slips in.
  always_comb begin
    sel        = (state_q == LOCKED) ? owner_q : pick_idx;
    grant_mask = (state_q == LOCKED) ? (NREQ'(1) << owner_q) : pick_gnt;
    req_ready  = (reset_L && !full) ? grant_mask : '0;
    accept     = |(req_ready & req_valid);
    sel_last   = req_last[sel];
    push       = accept;
    wdata      = accept ? data_a[sel] : '0;
  end

  always_ff @(posedge wclk or negedge reset_L) begin
    if (!reset_L) begin
      rr_ptr_q <= '0;
      owner_q  <= '0;
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (accept) begin
      if (state_q == IDLE) owner_q <= sel;
      if (sel_last) begin
        rr_ptr_q <= IW'(rr_next(int'(sel), NREQ));
        if (cnt_q[sel] != '1) cnt_q[sel] <= cnt_q[sel] + CNT_WIDTH'(1);
      end
    end
  end

  assign busy    = (state_q == LOCKED);
  assign lock_id = owner_q;

  a_ready_onehot: assert property (@(posedge wclk) disable iff (!reset_L) $onehot0(req_ready));
  a_push_is_accept: assert property (@(posedge wclk) disable iff (!reset_L) push == |(req_ready & req_valid));

endmodule
